// File: rtl/fpadd_accumulator_if.sv
// fpadd_accumulator_if: run control, input stream and result handshake of the accumulator
interface fpadd_accumulator_if #(parameter int CNT_W = 8) ();
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      sum;
  logic [CNT_W-1:0] count;
  logic             busy;
  modport master (output start, len, in_valid, in_data, out_ready,
                  input in_ready, out_valid, sum, count, busy);
  modport slave  (input start, len, in_valid, in_data, out_ready,
                  output in_ready, out_valid, sum, count, busy);
endinterface

// File: rtl/fpadd_accumulator.sv
// fpadd_accumulator: streaming binary32 accumulator around a combinational fpadd
// fpadd rounds to nearest-even; any NaN operand or Inf-Inf yields quiet NaN 7FC00000
module fpadd (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s
);
  logic        w_swap, w_sub, w_nan, w_rnd;
  logic [31:0] w_x, w_y;
  logic [7:0]  w_ex, w_ey, w_d;
  logic [26:0] w_mx, w_my, w_sh, w_al, w_n;
  logic [27:0] w_r;
  logic [9:0]  w_e;
  logic [4:0]  w_lz, w_shl;
  logic [24:0] w_m;
  assign w_swap = b[30:0] > a[30:0];
  assign w_x    = w_swap ? b : a;
  assign w_y    = w_swap ? a : b;
  assign w_ex   = (w_x[30:23] == 8'd0) ? 8'd1 : w_x[30:23];
  assign w_ey   = (w_y[30:23] == 8'd0) ? 8'd1 : w_y[30:23];
  assign w_mx   = {w_x[30:23] != 8'd0, w_x[22:0], 3'b000};
  assign w_my   = {w_y[30:23] != 8'd0, w_y[22:0], 3'b000};
  assign w_d    = w_ex - w_ey;
  // bits shifted out of the smaller operand collapse into the sticky lsb
  assign w_sh   = w_my >> w_d;
  assign w_al   = {w_sh[26:1], w_sh[0] | ((w_sh << w_d) != w_my)};
  assign w_sub  = w_x[31] ^ w_y[31];
  assign w_r    = w_sub ? {1'b0, w_mx} - {1'b0, w_al} : {1'b0, w_mx} + {1'b0, w_al};
  assign w_nan  = (&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0]) ||
                  (&a[30:23] && &b[30:23] && (a[31] != b[31]));
  always_comb begin
    w_lz = 5'd27;
    for (int i = 0; i < 27; i++) if (w_r[i]) w_lz = 5'(26 - i);
    w_shl = (10'(w_lz) > 10'(w_ex) - 10'd1) ? 5'(w_ex - 8'd1) : w_lz;
    w_n   = w_r[27] ? {w_r[27:2], |w_r[1:0]} : w_r[26:0] << w_shl;
    w_e   = w_r[27] ? 10'(w_ex) + 10'd1 : 10'(w_ex) - 10'(w_shl);
    w_rnd = w_n[2] & (w_n[3] | w_n[1] | w_n[0]);
    w_m   = {1'b0, w_n[26:3]} + 25'(w_rnd);
    w_e   = w_e + 10'(w_m[24]);
    s = {w_x[31], ((w_m[24] | w_m[23]) ? w_e[7:0] : 8'd0), (w_m[24] ? w_m[23:1] : w_m[22:0])};
    if (w_e >= 10'd255) s = {w_x[31], 8'hFF, 23'd0};
    if (w_r == 28'd0) s = {a[31] & b[31], 31'd0};
    if (&w_x[30:23]) s = w_x;
    if (w_nan) s = 32'h7FC0_0000;
  end
endmodule

module fpadd_accumulator #(parameter int CNT_W = 8) (
  input logic             clk,
  input logic             reset,
  fpadd_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t           r_state, w_next;
  logic [31:0]      r_acc, w_nxt;
  logic [CNT_W-1:0] r_count, r_len;
  logic             w_acc;
  fpadd u_fpadd (.a(r_acc), .b(bus.in_data), .s(w_nxt));
  assign w_acc = (r_state == ACCUM) && bus.in_valid;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = (bus.len == '0) ? DONE : ACCUM;
      ACCUM:   if (w_acc && (r_count + CNT_W'(1) == r_len)) w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready  = r_state == ACCUM;
    bus.out_valid = r_state == DONE;
    bus.busy      = r_state != IDLE;
    bus.sum       = r_acc;
    bus.count     = r_count;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_acc   <= '0;
      r_count <= '0;
      r_len   <= '0;
    end else if (r_state == IDLE && bus.start) begin
      r_acc   <= '0;
      r_count <= '0;
      r_len   <= bus.len;
    end else if (w_acc) begin
      r_acc   <= w_nxt;
      r_count <= r_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_fpadd_accumulator.sv
// tb_fpadd_accumulator: directed runs with hand-computed binary32 sums
module tb_fpadd_accumulator;
  logic clk = 0, reset = 0;
  int   n_vec = 0, n_err = 0;
  fpadd_accumulator_if #(8) bus ();
  fpadd_accumulator #(.CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] l);
    @(negedge clk);
    bus.start = 1; bus.len = l;
    @(negedge clk);
    bus.start = 0;
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    bus.in_valid = 1; bus.in_data = d;
    while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
    if (n == 20) chk("send_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 0;
  endtask

  task automatic take();
    bus.out_ready = 1;
    @(negedge clk);
    bus.out_ready = 0;
  endtask

  initial begin
    bus.start = 0; bus.len = 0; bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_count", 32'(bus.count), 0);
    reset = 1;
    // 1+2+3 back-to-back
    do_start(3);
    chk("t1_in_ready", 32'(bus.in_ready), 1);
    send(32'h3F800000); send(32'h40000000); send(32'h40400000);
    chk("t1_out_valid", 32'(bus.out_valid), 1);
    chk("t1_sum", bus.sum, 32'h40C00000);
    chk("t1_count", 32'(bus.count), 3);
    chk("t1_in_ready_done", 32'(bus.in_ready), 0);
    take();
    chk("t1_busy_after", 32'(bus.busy), 0);
    // zero-length run
    do_start(0);
    chk("t2_out_valid", 32'(bus.out_valid), 1);
    chk("t2_in_ready", 32'(bus.in_ready), 0);
    chk("t2_sum", bus.sum, 0);
    take();
    // gaps and output backpressure: 1.5+1.5
    do_start(2);
    send(32'h3FC00000);
    for (int i = 0; i < 4; i++) begin
      chk("t3_gap_count", 32'(bus.count), 1);
      @(negedge clk);
    end
    chk("t3_gap_sum", bus.sum, 32'h3FC00000);
    send(32'h3FC00000);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(bus.out_valid), 1);
      chk("t3_hold_sum", bus.sum, 32'h40400000);
      @(negedge clk);
    end
    take();
    chk("t3_released", 32'(bus.out_valid), 0);
    // cancellation, then start clears acc; Inf passes through
    do_start(2);
    chk("t4_cleared", bus.sum, 0);
    send(32'h3F800000); send(32'hBF800000);
    chk("t4_zero", bus.sum, 0);
    chk("t4_valid", 32'(bus.out_valid), 1);
    take();
    do_start(1);
    send(32'h7F800000);
    chk("t4_inf", bus.sum, 32'h7F800000);
    take();
    // start during ACCUM is ignored
    do_start(2);
    send(32'h3F800000);
    do_start(5);
    send(32'h40000000);
    chk("t5_valid", 32'(bus.out_valid), 1);
    chk("t5_count", 32'(bus.count), 2);
    chk("t5_sum", bus.sum, 32'h40400000);
    take();
    // async reset mid-run
    do_start(4);
    send(32'h3F800000); send(32'h40000000);
    chk("t6_partial", bus.sum, 32'h40400000);
    reset = 0;
    #1;
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_in_ready", 32'(bus.in_ready), 0);
    chk("t6_sum", bus.sum, 0);
    chk("t6_count", 32'(bus.count), 0);
    @(negedge clk);
    reset = 1;
    do_start(1);
    send(32'h41200000);
    chk("t6_fresh_sum", bus.sum, 32'h41200000);
    chk("t6_fresh_count", 32'(bus.count), 1);
    take();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
